// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multicycle fetch/decode/execute sequencer driving the CPU datapath controls,
// with condition evaluation against stored NZCV and a handshake timeout watchdog.
module cpu_seq_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        MemWrite,
    input  logic [3:0]  ALUFlags,
    output logic [31:0] Instr,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        MemtoReg,
    output logic        PCSrc,
    output logic        PCWrite,
    output logic [3:0]  flags,
    output logic        retired,
    output logic        illegal,
    output logic        bus_error
);
    typedef enum logic [3:0] {FETCH, DECODE, EXEC, WB, DONE, MEMRD, MEMWB, MEMWR, BR} state_t;
    state_t state, state_next;
    logic [31:0] cnt, cnt_next;
    logic [3:0] cond, cmd;
    logic [1:0] op, alu_dp;
    logic n, z, c, v, cond_pass, legal, waiting, timeout;

    assign cond = Instr[31:28];
    assign op = Instr[27:26];
    assign cmd = Instr[24:21];
    assign {n, z, c, v} = flags;
    assign legal = (op == 2'b01) || (op == 2'b10) || (op == 2'b00 && cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010});
    assign alu_dp = cmd == 4'b0000 ? 2'b10 : cmd == 4'b1100 ? 2'b11 : (cmd == 4'b0010 || cmd == 4'b1010) ? 2'b01 : 2'b00;
    assign waiting = (state == FETCH && !imem_ready) || ((state == MEMRD || state == MEMWR) && !dmem_ready);
    assign timeout = waiting && WAIT_LIMIT != 0 && cnt == WAIT_LIMIT;
    assign cnt_next = (timeout || state_next != state) ? 32'd0 : waiting ? cnt + 32'd1 : cnt;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = n == v;
            4'b1011: cond_pass = n != v;
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        MemWrite = 1'b0;
        RegSrc = 2'b00;
        RegWrite = 1'b0;
        ImmSrc = 2'b00;
        ALUSrc = 1'b0;
        ALUControl = 2'b00;
        MemtoReg = 1'b0;
        PCSrc = 1'b0;
        PCWrite = 1'b0;
        retired = 1'b0;
        illegal = 1'b0;
        bus_error = 1'b0;
        if (reset) begin
            // operand controls stay valid from EXEC until the instruction retires
            if (state inside {EXEC, WB, DONE, MEMRD, MEMWB, MEMWR, BR}) begin
                ImmSrc = op;
                ALUSrc = op == 2'b00 ? Instr[25] : 1'b1;
                ALUControl = op == 2'b00 ? alu_dp : 2'b00;
                RegSrc = op == 2'b01 ? {~Instr[20], 1'b0} : op == 2'b10 ? 2'b01 : 2'b00;
            end
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    state_next = imem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    illegal = cond_pass && !legal;
                    PCWrite = !(cond_pass && legal);
                    retired = !(cond_pass && legal);
                    state_next = (cond_pass && legal) ? EXEC : FETCH;
                end
                EXEC: state_next = op == 2'b01 ? (Instr[20] ? MEMRD : MEMWR) : op == 2'b10 ? BR : cmd == 4'b1010 ? DONE : WB;
                WB: begin
                    RegWrite = 1'b1;
                    PCWrite = 1'b1;
                    retired = 1'b1;
                    state_next = FETCH;
                end
                MEMRD: begin
                    dmem_req = 1'b1;
                    state_next = dmem_ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    PCWrite = 1'b1;
                    retired = 1'b1;
                    state_next = FETCH;
                end
                MEMWR: begin
                    dmem_req = 1'b1;
                    MemWrite = 1'b1;
                    PCWrite = dmem_ready;
                    retired = dmem_ready;
                    state_next = dmem_ready ? FETCH : MEMWR;
                end
                BR: begin
                    PCSrc = 1'b1;
                    PCWrite = 1'b1;
                    retired = 1'b1;
                    state_next = FETCH;
                end
                default: begin
                    PCWrite = 1'b1;
                    retired = 1'b1;
                    state_next = FETCH;
                end
            endcase
            if (timeout) begin
                bus_error = 1'b1;
                PCWrite = 1'b1;
                state_next = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            cnt <= 32'd0;
            Instr <= 32'd0;
            flags <= 4'd0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            if (state == FETCH && imem_ready)
                Instr <= imem_rdata;
            if (state == EXEC && op == 2'b00 && Instr[20])
                flags <= ALUFlags;
        end
    end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multicycle sequencer for the single-issue CPU datapath. It fetches an instruction through an imem req/ready handshake, holds it in an instruction register, decodes it, and evaluates its condition code against a stored NZCV register. It then drives the datapath controls (RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc) plus PC-write and data-memory handshake strobes, one state per step.

Parameters:
WAIT_LIMIT, 16, maximum cycles spent waiting for imem_ready or dmem_ready before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
imem_rdata  in  32  instruction from instruction memory
imem_ready  in  1  instruction-fetch complete
imem_req  out  1  instruction-fetch request
dmem_ready  in  1  data access complete
dmem_req  out  1  data access request
MemWrite  out  1  data access is a write
ALUFlags  in  4  {N,Z,C,V} from datapath ALU
Instr  out  32  instruction register contents to datapath
RegSrc  out  2  [0]=read R15 as RA1, [1]=read Rd as RA2
RegWrite  out  1  register-file write enable
ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24 branch
ALUSrc  out  1  1 = immediate operand
ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
MemtoReg  out  1  1 = write back ReadData
PCSrc  out  1  1 = PC loads Result
PCWrite  out  1  PC register load enable
flags  out  4  stored NZCV
retired  out  1  one-cycle pulse per completed or skipped instruction
illegal  out  1  one-cycle pulse on undefined op/cmd
bus_error  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, Instr=0, flags=0, wait counter=0. All outputs are 0 while reset is low; requests drop immediately. After release, imem_req rises in the first FETCH cycle.
- Decode fields of Instr: cond[31:28], op[27:26], I=Instr[25], cmd[24:21], S=Instr[20], L=Instr[20] for op=01.
- States:
  - FETCH: imem_req=1 until imem_ready. On ready: Instr<=imem_rdata, go to DECODE.
  - DECODE: evaluate cond on flags. Codes 0000..1101 are standard ARM, 1110=always, 1111=never.
    - cond false: PCWrite=1, PCSrc=0, retired=1, go to FETCH.
    - op=11, or op=00 with cmd outside {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP}: illegal=1, PCWrite=1, retired=1, go to FETCH.
    - Otherwise go to EXEC.
  - EXEC: ALU operands are valid this cycle.
    - op=00: ALUSrc=I, ImmSrc=00, ALUControl from cmd (CMP uses 01). If S=1, flags<=ALUFlags at the clock edge. Then WB; CMP goes to DONE.
    - op=01: ALUSrc=1, ImmSrc=01, ALUControl=00, RegSrc[1]=~L. Then MEMRD if L=1, else MEMWR.
    - op=10: RegSrc[0]=1, ALUSrc=1, ImmSrc=10, ALUControl=00. Then BR.
  - WB: RegWrite=1, MemtoReg=0, PCWrite=1, PCSrc=0, retired=1, go to FETCH.
  - DONE: PCWrite=1, retired=1, go to FETCH.
  - MEMRD: dmem_req=1, MemWrite=0, address controls held as in EXEC. On dmem_ready go to MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, PCWrite=1, retired=1, go to FETCH.
  - MEMWR: dmem_req=1, MemWrite=1, RegSrc[1]=1, controls held. In the cycle dmem_ready=1: PCWrite=1, retired=1, go to FETCH.
  - BR: RegSrc[0]=1, ALUSrc=1, ImmSrc=10, PCSrc=1, PCWrite=1, retired=1, go to FETCH.
- Latency with zero-wait memory:
  - DP: 4 cycles. CMP: 4 cycles. Branch: 4 cycles.
  - LDR: 5 cycles. STR: 4 cycles.
  - Condition-failed or illegal: 2 cycles.
- All outputs are decoded from state and Instr only (Moore), except that the MEMWR-exit PCWrite/retired depend on dmem_ready.
- Handshakes:
  - Requests stay high until ready. Ready while req=0 is ignored.
  - Request data and controls are stable for the whole request.
- Timeout:
  - The counter increments each waiting cycle of FETCH/MEMRD/MEMWR and clears on state change.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with no ready: bus_error=1, PCWrite=1, PCSrc=0, retired=0, RegWrite=0, go to FETCH.
  - A FETCH timeout leaves Instr unchanged.
  - Ready in the same cycle as limit reach: ready wins.
- Exactly one PCWrite pulse per instruction. RegWrite is never asserted in the same cycle as dmem_req.
- Flags change only in EXEC with S=1 on a passed condition, or on reset.

Test Plan:
- Reset low mid-MEMWR with dmem_req=1 -> dmem_req, MemWrite and PCWrite drop within the same cycle; after release, FETCH with Instr=0 and flags=0.
- ADDS R1 (Instr=32'hE2911005, imem_ready immediate), ALUFlags=4'b0100 -> RegWrite=1 in cycle 4, flags=4'b0100 after EXEC, ALUControl=00, ALUSrc=1, one retired pulse.
- BEQ (32'h0A000002) with flags Z=0 -> DECODE skip, PCWrite=1, PCSrc=0 at cycle 2, no RegWrite. Same with Z=1 -> BR cycle with PCSrc=1, RegSrc=2'b01.
- LDR (32'hE5912004), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, MemWrite=0, then MEMWB with RegWrite=1 and MemtoReg=1.
- STR with dmem_ready never asserted, WAIT_LIMIT=16 -> bus_error pulse after 16 wait cycles, PCWrite=1, retired=0, back to FETCH.
- Instr=32'hEC000000 (op=11) -> illegal pulse in DECODE, PCWrite=1, no RegWrite/dmem_req, flags unchanged.
